// File: rtl/msg_payload_arbiter.sv
// msg_payload_arbiter: round-robin arbiter sharing one msg_parser input between NUM_SRC payload streams
// Ports:
//   clk, reset_n                    clock; synchronous active-low reset
//   src_valid/sop/eop/data/ready    per-source beat streams (source i data at [i*DATA_WIDTH +: DATA_WIDTH])
//   dn_valid/sop/eop/data/ready     forwarded stream towards the parser
//   grant_valid, grant_id           current payload owner
//   payload_cnt                     completed payloads, wraps at 16 bits
//   err_sticky                      per-source protocol errors, cleared only by reset
//   timeout_pulse                   stall watchdog release; built only with MSG_ARB_WATCHDOG_EN defined
module msg_payload_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC-1:0]            src_sop,
  input  logic [NUM_SRC-1:0]            src_eop,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic                          dn_valid,
  output logic                          dn_sop,
  output logic                          dn_eop,
  output logic [DATA_WIDTH-1:0]         dn_data,
  input  logic                          dn_ready,
  output logic                          grant_valid,
  output logic [$clog2(NUM_SRC)-1:0]    grant_id,
  output logic [15:0]                   payload_cnt,
  output logic [NUM_SRC-1:0]            err_sticky,
  output logic                          timeout_pulse
);
  localparam int IW = $clog2(NUM_SRC);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] rr_ptr, pick, idx, ptr_nxt;
  logic [DATA_WIDTH-1:0] data_arr [NUM_SRC];
  logic [NUM_SRC-1:0] req, flush, g_hot, err_set;
  logic busy, accept, last, first, wd_fire;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign data_arr[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
  end
  assign busy = state == BUSY;
  assign grant_valid = busy;
  assign req = src_valid & src_sop;
  assign g_hot = NUM_SRC'(1) << grant_id;
  assign accept = busy & src_valid[grant_id] & dn_ready;
  assign last = accept & src_eop[grant_id];
  // beats without sop seen while idle can never start a payload, so they are drained
  assign flush = busy ? '0 : src_valid & ~src_sop;
  assign ptr_nxt = IW'((int'(grant_id) + 1) % NUM_SRC);
  // first beat of the payload is exempt from the repeated-sop check
  assign err_set = flush | (((accept & src_sop[grant_id] & ~first) | wd_fire) ? g_hot : '0);
  // walk from the highest offset down so the requester nearest rr_ptr wins
  always_comb begin
    pick = rr_ptr;
    idx = rr_ptr;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_ptr) + k) % NUM_SRC);
      pick = req[idx] ? idx : pick;
    end
  end
  always_comb begin
    state_nxt = busy ? ((last | wd_fire) ? IDLE : BUSY) : (|req ? BUSY : IDLE);
    dn_valid = busy & src_valid[grant_id];
    dn_sop = busy & src_sop[grant_id];
    dn_eop = busy & src_eop[grant_id];
    dn_data = busy ? data_arr[grant_id] : '0;
    src_ready = busy ? (dn_ready ? g_hot : '0) : flush;
  end
  always_ff @(posedge clk) state <= reset_n ? state_nxt : IDLE;
  always_ff @(posedge clk)
    if (!reset_n) begin
      rr_ptr <= '0;
      grant_id <= '0;
      payload_cnt <= '0;
      err_sticky <= '0;
      first <= 1'b0;
    end else begin
      if (!busy && |req) grant_id <= pick;
      first <= busy ? first & ~accept : 1'b1;
      if (last | wd_fire) rr_ptr <= ptr_nxt;
      if (last) payload_cnt <= payload_cnt + 16'd1;
      err_sticky <= err_sticky | err_set;
    end
`ifdef MSG_ARB_WATCHDOG_EN
  logic [15:0] stall_cnt;
  // fires on the stalled cycle that brings the count up to TIMEOUT_CYC
  assign wd_fire = busy & ~accept & (stall_cnt == 16'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk)
    if (!reset_n) begin
      stall_cnt <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      stall_cnt <= (busy & ~accept & ~wd_fire) ? stall_cnt + 16'd1 : '0;
      timeout_pulse <= wd_fire;
    end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYC;
  assign wd_fire = 1'b0;
  assign timeout_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_msg_payload_arbiter.sv
// tb_msg_payload_arbiter: randomized payload sources checked against an owner/queue model of the arbiter
module tb_msg_payload_arbiter;
  localparam int N = 4;
  localparam int W = 64;
  logic clk = 0;
  logic reset_n;
  logic [N-1:0] v, s, e, src_ready, err_sticky;
  logic [W-1:0] d [N];
  logic [N*W-1:0] src_data;
  logic dn_valid, dn_sop, dn_eop, dn_ready, grant_valid, timeout_pulse;
  logic [W-1:0] dn_data;
  logic [1:0] grant_id;
  logic [15:0] payload_cnt;

  msg_payload_arbiter #(.NUM_SRC(N), .DATA_WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .src_valid(v), .src_sop(s), .src_eop(e), .src_data(src_data),
    .src_ready(src_ready), .dn_valid(dn_valid), .dn_sop(dn_sop), .dn_eop(dn_eop), .dn_data(dn_data),
    .dn_ready(dn_ready), .grant_valid(grant_valid), .grant_id(grant_id), .payload_cnt(payload_cnt),
    .err_sticky(err_sticky), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;
  for (genvar i = 0; i < N; i++) begin : g_pack
    assign src_data[i*W +: W] = d[i];
  end

  int vectors = 0, errors = 0;
  // source generators
  logic [N-1:0] en, acc, gb;
  int pos [N], len [N];
  int lmin, lmax, p_valid, p_garb, p_rsop, p_ready;
  bit rtoggle, rst_seen;
  // model: who owns the port, where the search starts, what has been counted
  int m_owner = -1, m_ptr = 0, co;
  logic m_first;
  logic [15:0] m_cnt;
  logic [N-1:0] m_err;
  int dv_cnt = 0, se_cnt = 0, dv0, se0;
  logic [31:0] gseq;
  logic gv_prev = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] exp_ready();
    if (m_owner < 0) return v & ~s;
    return dn_ready ? N'(1) << m_owner : '0;
  endfunction

  task automatic tick();
    int c;
    @(posedge clk);
    if (!reset_n) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_err = 0; m_first = 0; acc = 0; rst_seen = 1;
    end else begin
      acc = v & exp_ready();
      if (m_owner < 0) begin
        m_err |= v & ~s;
        c = -1;
        for (int k = 0; k < N; k++)
          if (c < 0 && v[(m_ptr + k) % N] && s[(m_ptr + k) % N]) c = (m_ptr + k) % N;
        if (c >= 0) begin m_owner = c; m_first = 1; end
      end else if (acc[m_owner]) begin
        if (s[m_owner] && !m_first) m_err[m_owner] = 1;
        m_first = 0;
        if (e[m_owner]) begin m_cnt++; m_ptr = (m_owner + 1) % N; m_owner = -1; end
      end
    end
    #1;
    if (grant_valid === 1'b1 && gv_prev === 1'b0) gseq = {gseq[27:0], 2'b00, grant_id};
    gv_prev = grant_valid;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rst_seen) begin pos[i] = 0; v[i] = 0; end
      else if (acc[i]) begin
        if (!gb[i]) pos[i] = e[i] ? 0 : pos[i] + 1;
        v[i] = 0;
      end
      if (!en[i] && pos[i] == 0) v[i] = 0;
      if (!v[i] && en[i] && $urandom_range(99) < p_valid) begin
        if (pos[i] == 0) len[i] = $urandom_range(lmax, lmin);
        gb[i] = pos[i] == 0 && $urandom_range(99) < p_garb;
        s[i] = !gb[i] && (pos[i] == 0 || $urandom_range(99) < p_rsop);
        e[i] = !gb[i] && pos[i] == len[i] - 1;
        d[i] = {$urandom, $urandom};
        v[i] = 1;
      end
    end
    rst_seen = 0;
    dn_ready = rtoggle ? ~dn_ready : ($urandom_range(99) < p_ready);
  endtask

  task automatic run_until(input logic [15:0] target, input int budget, input string nm);
    int n = 0;
    tick();
    while (payload_cnt !== target && n < budget) begin drive(); tick(); n++; end
    chk(nm, payload_cnt, target);
  endtask

  // the single per-cycle compare against the model
  always @(negedge clk) if (reset_n) begin
    co = m_owner < 0 ? 0 : m_owner;
    chk("src_ready", src_ready, exp_ready());
    chk("dn_valid", dn_valid, m_owner >= 0 && v[co]);
    chk("grant_valid", grant_valid, m_owner >= 0);
    if (m_owner >= 0) chk("grant_id", grant_id, m_owner);
    if (m_owner >= 0 && v[co]) begin
      chk("dn_sop", dn_sop, s[co]);
      chk("dn_eop", dn_eop, e[co]);
      chk("dn_data", dn_data, d[co]);
    end
    if (m_owner < 0) chk("dn_data_idle", dn_data, 0);
    chk("payload_cnt", payload_cnt, m_cnt);
    chk("err_sticky", err_sticky, m_err);
    chk("timeout_pulse", timeout_pulse, 0);
    if (dn_valid) dv_cnt++;
    if (dn_valid && dn_ready && dn_sop && dn_eop) se_cnt++;
  end

  initial begin
    reset_n = 0; v = 0; s = 0; e = 0; en = 0; acc = 0; gb = 0; dn_ready = 0; rtoggle = 0;
    lmin = 1; lmax = 1; p_valid = 100; p_garb = 0; p_rsop = 0; p_ready = 100;
    for (int i = 0; i < N; i++) begin d[i] = 0; pos[i] = 0; len[i] = 1; end
    repeat (3) tick();
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_payload_cnt", payload_cnt, 0);
    chk("rst_err_sticky", err_sticky, 0);
    chk("rst_dn_valid", dn_valid, 0);
    chk("rst_timeout", timeout_pulse, 0);
    reset_n = 1;
    // all four sources, back-to-back 3-beat payloads
    en = 4'b1111; lmin = 3; lmax = 3;
    gseq = 0; dv0 = dv_cnt;
    drive();
    run_until(16'd8, 100, "b2b_cnt");
    chk("b2b_order", gseq, 32'h0123_0123);
    chk("b2b_dn_cycles", dv_cnt - dv0, 24);
    en = 0; drive(); tick();
    // source 2 alone with dn_ready toggling
    en = 4'b0100; rtoggle = 1;
    drive(); tick();
    chk("toggle_grant", grant_id, 2);
    drive();
    run_until(16'd9, 60, "toggle_cnt");
    en = 0; rtoggle = 0; drive(); tick();
    // single-beat payload on source 1
    en = 4'b0010; lmin = 1; lmax = 1; se0 = se_cnt;
    drive();
    run_until(16'd10, 20, "single_cnt");
    chk("single_release", grant_valid, 0);
    chk("single_sop_eop", se_cnt - se0, 1);
    en = 0; drive(); tick();
    // source 3 sends beats without sop while idle
    en = 4'b1000; p_garb = 100; dv0 = dv_cnt;
    drive();
    repeat (4) begin tick(); drive(); end
    #1 chk("flush_ready", src_ready[3], 1);
    tick();
    chk("flush_err", err_sticky, 4'b1000);
    chk("flush_dn_idle", dv_cnt - dv0, 0);
    en = 0; p_garb = 0; drive(); tick();
    // reset in the middle of a payload on source 0
    en = 4'b0001; lmin = 4; lmax = 4;
    drive(); tick(); drive(); tick(); drive();
    reset_n = 0;
    tick();
    chk("rst_mid_gv", grant_valid, 0);
    chk("rst_mid_cnt", payload_cnt, 0);
    chk("rst_mid_err", err_sticky, 0);
    chk("rst_mid_dnv", dn_valid, 0);
    reset_n = 1; en = 4'b1001;
    drive(); tick();
    chk("rst_regrant_gv", grant_valid, 1);
    chk("rst_regrant_id", grant_id, 0);
    drive();
    run_until(16'd1, 40, "rst_resend_cnt");
    en = 0; drive(); tick();
    // randomized traffic with gaps, garbage, repeated sop, backpressure and one reset
    en = 4'b1111; lmin = 1; lmax = 4; p_valid = 70; p_garb = 5; p_rsop = 5; p_ready = 70;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) reset_n = 0;
      if (i == 1502) reset_n = 1;
      drive();
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
